mem_access_unit: RTL and testbench

CPU-side initiator for the byte-addressed, big-endian data memory. It accepts one load/store request at a time from the datapath over a valid/ready handshake and runs it as a sequence of single-byte accesses on a byte-wide memory port. For loads it assembles the bytes and sign- or zero-extends the result. It rejects misaligned, out-of-range and reserved-size requests without touching memory.

---
 rtl/mau_pkg.sv | 30 +++
 rtl/mau_if.sv | 29 ++
 rtl/mau_extend.sv | 20 ++
 rtl/mem_access_unit.sv | 124 ++++++++++++
 tb/tb_mem_access_unit.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mau_pkg.sv
// Shared size codes, FSM encodings and helpers for the memory access unit.
package mau_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  // Request attributes held for the lifetime of one access.
  typedef struct packed {
    logic       rw;
    logic [1:0] size;
    logic       sgn;
    logic       err;
  } req_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mau_if.sv
// Datapath request/response bus and byte-wide memory port of the access unit.
interface mau_req_if #(parameter int ADDR_W = 32);
  logic              valid;
  logic              ready;
  logic              rw;
  logic [1:0]        size;
  logic              sgn;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (output valid, rw, size, sgn, addr, wdata,
                  input  ready, resp_valid, resp_rdata, resp_err);
  modport slave  (input  valid, rw, size, sgn, addr, wdata,
                  output ready, resp_valid, resp_rdata, resp_err);
endinterface

interface mau_mem_if #(parameter int ADDR_W = 32);
  logic              en;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata;
  logic [7:0]        rdata;

  modport master (output en, rw, addr, wdata, input rdata);
  modport slave  (input en, rw, addr, wdata, output rdata);
endinterface

// File: rtl/mau_extend.sv
// Sign/zero extension of an assembled load value of 1, 2 or 4 bytes.
module mau_extend
  import mau_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] ext
);

  always_comb begin
    ext = raw;
    case (size)
      SZ_BYTE: ext = {{24{sgn & raw[7]}}, raw[7:0]};
      SZ_HALF: ext = {{16{sgn & raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Runs one load/store as a sequence of big-endian single-byte memory accesses.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int MEM_BYTES = 512,
  parameter int ADDR_W    = 32
) (
  input  logic       clk,
  input  logic       rst,
  mau_req_if.slave   req,
  mau_mem_if.master  mem
);

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  logic [1:0]        state_reg;
  req_t              cur_reg;
  logic [1:0]        idx_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       data_reg;
  logic              mem_en_reg;
  logic              mem_rw_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [7:0]        mem_wdata_reg;

  logic [2:0]        req_n;
  logic [1:0]        align_mask;
  logic [ADDR_W:0]   req_end;
  logic              req_err;
  logic [31:0]       wdata_aligned;
  logic [1:0]        last_idx;
  logic [31:0]       ext_data;

  assign req_n      = size_bytes(req.size);
  assign align_mask = 2'(req_n - 3'd1);
  assign req_end    = {1'b0, req.addr} + {{(ADDR_W-2){1'b0}}, req_n};
  assign req_err    = (req.size == SZ_RSVD) || (|(req.addr[1:0] & align_mask)) ||
                      (req_end > MEM_LIMIT);
  assign last_idx   = 2'(size_bytes(cur_reg.size) - 3'd1);

  // Store bytes are left-justified so the MSB always leaves from bits [31:24].
  always_comb begin
    wdata_aligned = req.wdata;
    case (req.size)
      SZ_BYTE: wdata_aligned = {req.wdata[7:0], 24'd0};
      SZ_HALF: wdata_aligned = {req.wdata[15:0], 16'd0};
      default: wdata_aligned = req.wdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cur_reg       <= '0;
      idx_reg       <= '0;
      wdata_reg     <= '0;
      data_reg      <= '0;
      mem_en_reg    <= 1'b0;
      mem_rw_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req.valid) begin
            cur_reg  <= '{rw: req.rw, size: req.size, sgn: req.sgn, err: req_err};
            idx_reg  <= '0;
            data_reg <= '0;
            if (req_err) begin
              state_reg <= RESP;
            end else begin
              state_reg     <= ISSUE;
              mem_en_reg    <= 1'b1;
              mem_rw_reg    <= req.rw;
              mem_addr_reg  <= req.addr;
              mem_wdata_reg <= wdata_aligned[31:24];
              wdata_reg     <= wdata_aligned << 8;
            end
          end
        end
        ISSUE: begin
          // Read data lags its strobe by one cycle, so capture trails the index.
          if (!cur_reg.rw && idx_reg != 2'd0)
            data_reg <= {data_reg[23:0], mem.rdata};
          if (idx_reg == last_idx) begin
            mem_en_reg    <= 1'b0;
            mem_rw_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            state_reg     <= cur_reg.rw ? RESP : DRAIN;
          end else begin
            idx_reg       <= idx_reg + 2'd1;
            mem_addr_reg  <= mem_addr_reg + ADDR_W'(1);
            mem_wdata_reg <= wdata_reg[31:24];
            wdata_reg     <= wdata_reg << 8;
          end
        end
        DRAIN: begin
          data_reg  <= {data_reg[23:0], mem.rdata};
          state_reg <= RESP;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  mau_extend u_extend (
    .raw  (data_reg),
    .size (cur_reg.size),
    .sgn  (cur_reg.sgn),
    .ext  (ext_data)
  );

  assign req.ready      = (state_reg == IDLE);
  assign req.resp_valid = (state_reg == RESP);
  assign req.resp_err   = (state_reg == RESP) && cur_reg.err;
  assign req.resp_rdata = ((state_reg == RESP) && !cur_reg.err && !cur_reg.rw) ? ext_data : 32'd0;

  assign mem.en    = mem_en_reg;
  assign mem.rw    = mem_rw_reg;
  assign mem.addr  = mem_addr_reg;
  assign mem.wdata = mem_wdata_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-wide memory model.
module tb_mem_access_unit;

  typedef struct {
    logic [63:0] name;
    logic        rw;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] raw;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] exp;
  } ext_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mau_req_if #(.ADDR_W(32)) req_bus ();
  mau_mem_if #(.ADDR_W(32)) mem_bus ();

  mem_access_unit #(.MEM_BYTES(512), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .req (req_bus),
    .mem (mem_bus)
  );

  logic [31:0] ext_raw;
  logic [1:0]  ext_size;
  logic        ext_sgn;
  logic [31:0] ext_out;

  mau_extend u_ext (
    .raw  (ext_raw),
    .size (ext_size),
    .sgn  (ext_sgn),
    .ext  (ext_out)
  );

  logic [7:0] mem_arr [0:511];
  logic       load_en;
  logic [8:0] load_addr;
  logic [7:0] load_data;

  always @(posedge clk) begin
    if (load_en)
      mem_arr[load_addr] <= load_data;
    else if (mem_bus.en) begin
      if (mem_bus.rw)
        mem_arr[mem_bus.addr[8:0]] <= mem_bus.wdata;
      else
        mem_bus.rdata <= mem_arr[mem_bus.addr[8:0]];
    end
  end

  vec_t vecs [20];
  ext_t exts [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  task automatic run_req(input vec_t v);
    int    n;
    logic  exp_en;
    string nm;
    n  = nbytes(v.size);
    nm = $sformatf("%s", v.name);
    @(negedge clk);
    chk({nm, " ready"}, 32'(req_bus.ready), 32'd1);
    req_bus.valid = 1'b1;
    req_bus.rw    = v.rw;
    req_bus.size  = v.size;
    req_bus.sgn   = v.sgn;
    req_bus.addr  = v.addr;
    req_bus.wdata = v.wdata;
    @(posedge clk);
    #1;
    // Scramble the request fields to prove they were registered.
    req_bus.valid = 1'b0;
    req_bus.rw    = ~v.rw;
    req_bus.size  = ~v.size;
    req_bus.sgn   = ~v.sgn;
    req_bus.addr  = 32'h0000_0155;
    req_bus.wdata = 32'h5A5A_5A5A;
    for (int c = 1; c <= v.lat; c++) begin
      @(negedge clk);
      exp_en = !v.exp_err && (c <= n);
      chk($sformatf("%s en c%0d", nm, c), 32'(mem_bus.en), 32'(exp_en));
      if (exp_en) begin
        chk($sformatf("%s addr c%0d", nm, c), mem_bus.addr, v.addr + 32'(c - 1));
        chk($sformatf("%s rw c%0d", nm, c), 32'(mem_bus.rw), 32'(v.rw));
        if (v.rw)
          chk($sformatf("%s wdata c%0d", nm, c), 32'(mem_bus.wdata),
              (v.wdata >> (8 * (n - c))) & 32'hFF);
      end
      chk($sformatf("%s rvalid c%0d", nm, c), 32'(req_bus.resp_valid), 32'(c == v.lat));
      if (c == v.lat) begin
        chk({nm, " rdata"}, req_bus.resp_rdata, v.exp_rdata);
        chk({nm, " err"}, 32'(req_bus.resp_err), 32'(v.exp_err));
        $display("txn %s addr=0x%03h rdata=0x%08h err=%0b cycle=%0d",
                 nm, v.addr, req_bus.resp_rdata, req_bus.resp_err, c);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{"LW10",    1'b0, 2'b10, 1'b0, 32'h010, 32'h0,        32'h8012_3456, 1'b0, 6};
    vecs[1]  = '{"LB10S",   1'b0, 2'b00, 1'b1, 32'h010, 32'h0,        32'hFFFF_FF80, 1'b0, 3};
    vecs[2]  = '{"LBU10",   1'b0, 2'b00, 1'b0, 32'h010, 32'h0,        32'h0000_0080, 1'b0, 3};
    vecs[3]  = '{"LH12S",   1'b0, 2'b01, 1'b1, 32'h012, 32'h0,        32'h0000_3456, 1'b0, 4};
    vecs[4]  = '{"LHU10",   1'b0, 2'b01, 1'b0, 32'h010, 32'h0,        32'h0000_8012, 1'b0, 4};
    vecs[5]  = '{"LH10S",   1'b0, 2'b01, 1'b1, 32'h010, 32'h0,        32'hFFFF_8012, 1'b0, 4};
    vecs[6]  = '{"SW20",    1'b1, 2'b10, 1'b0, 32'h020, 32'hDEAD_BEEF, 32'h0,        1'b0, 5};
    vecs[7]  = '{"LW20",    1'b0, 2'b10, 1'b0, 32'h020, 32'h0,        32'hDEAD_BEEF, 1'b0, 6};
    vecs[8]  = '{"SH30",    1'b1, 2'b01, 1'b0, 32'h030, 32'hFFFF_BEEF, 32'h0,        1'b0, 3};
    vecs[9]  = '{"LH30S",   1'b0, 2'b01, 1'b1, 32'h030, 32'h0,        32'hFFFF_BEEF, 1'b0, 4};
    vecs[10] = '{"LW11E",   1'b0, 2'b10, 1'b0, 32'h011, 32'h0,        32'h0,         1'b1, 1};
    vecs[11] = '{"LH13E",   1'b0, 2'b01, 1'b0, 32'h013, 32'h0,        32'h0,         1'b1, 1};
    vecs[12] = '{"RSVD10",  1'b0, 2'b11, 1'b0, 32'h010, 32'h0,        32'h0,         1'b1, 1};
    vecs[13] = '{"LW200E",  1'b0, 2'b10, 1'b0, 32'h200, 32'h0,        32'h0,         1'b1, 1};
    vecs[14] = '{"SW1FC",   1'b1, 2'b10, 1'b0, 32'h1FC, 32'hCAFE_F00D, 32'h0,        1'b0, 5};
    vecs[15] = '{"SB1FF",   1'b1, 2'b00, 1'b0, 32'h1FF, 32'h1234_56A5, 32'h0,        1'b0, 2};
    vecs[16] = '{"LW1FC",   1'b0, 2'b10, 1'b0, 32'h1FC, 32'h0,        32'hCAFE_F0A5, 1'b0, 6};
    vecs[17] = '{"LB1FFS",  1'b0, 2'b00, 1'b1, 32'h1FF, 32'h0,        32'hFFFF_FFA5, 1'b0, 3};
    vecs[18] = '{"LB200E",  1'b0, 2'b00, 1'b0, 32'h200, 32'h0,        32'h0,         1'b1, 1};
    vecs[19] = '{"LHU1FE",  1'b0, 2'b01, 1'b0, 32'h1FE, 32'h0,        32'h0000_F0A5, 1'b0, 4};

    exts[0] = '{32'h1234_5680, 2'b00, 1'b1, 32'hFFFF_FF80};
    exts[1] = '{32'h1234_5680, 2'b00, 1'b0, 32'h0000_0080};
    exts[2] = '{32'hAAAA_7FFF, 2'b01, 1'b1, 32'h0000_7FFF};
    exts[3] = '{32'h0000_8000, 2'b01, 1'b1, 32'hFFFF_8000};
    exts[4] = '{32'h1234_ABCD, 2'b01, 1'b0, 32'h0000_ABCD};
    exts[5] = '{32'h8765_4321, 2'b10, 1'b1, 32'h8765_4321};

    rst           = 1'b1;
    req_bus.valid = 1'b0;
    req_bus.rw    = 1'b0;
    req_bus.size  = 2'b00;
    req_bus.sgn   = 1'b0;
    req_bus.addr  = '0;
    req_bus.wdata = '0;
    load_en       = 1'b1;
    load_addr     = '0;
    load_data     = '0;

    for (int i = 0; i < 512; i++) begin
      load_addr = 9'(i);
      case (i)
        16'h10:  load_data = 8'h80;
        16'h11:  load_data = 8'h12;
        16'h12:  load_data = 8'h34;
        16'h13:  load_data = 8'h56;
        default: load_data = 8'h00;
      endcase
      @(posedge clk);
      #1;
    end
    load_en = 1'b0;

    @(negedge clk);
    chk("reset ready", 32'(req_bus.ready), 32'd1);
    chk("reset rvalid", 32'(req_bus.resp_valid), 32'd0);
    chk("reset rdata", req_bus.resp_rdata, 32'd0);
    chk("reset err", 32'(req_bus.resp_err), 32'd0);
    chk("reset en", 32'(mem_bus.en), 32'd0);
    chk("reset mrw", 32'(mem_bus.rw), 32'd0);
    chk("reset maddr", mem_bus.addr, 32'd0);
    chk("reset mwdata", 32'(mem_bus.wdata), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      ext_raw  = exts[i].raw;
      ext_size = exts[i].size;
      ext_sgn  = exts[i].sgn;
      #1;
      chk($sformatf("extend %0d", i), ext_out, exts[i].exp);
    end

    for (int i = 0; i < 20; i++)
      run_req(vecs[i]);

    // Back-to-back byte loads with valid held high.
    @(negedge clk);
    req_bus.valid = 1'b1;
    req_bus.rw    = 1'b0;
    req_bus.size  = 2'b00;
    req_bus.sgn   = 1'b1;
    req_bus.addr  = 32'h010;
    @(posedge clk);
    #1;
    req_bus.addr = 32'h012;
    req_bus.sgn  = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk($sformatf("b2b ready c%0d", c), 32'(req_bus.ready), 32'(c == 4));
      chk($sformatf("b2b rvalid c%0d", c), 32'(req_bus.resp_valid), 32'(c == 3 || c == 7));
      chk($sformatf("b2b en c%0d", c), 32'(mem_bus.en), 32'(c == 1 || c == 5));
      if (c == 5)
        chk("b2b addr2", mem_bus.addr, 32'h012);
      if (c == 3) begin
        chk("b2b rdata1", req_bus.resp_rdata, 32'hFFFF_FF80);
        $display("txn B2B1 addr=0x010 rdata=0x%08h err=%0b", req_bus.resp_rdata, req_bus.resp_err);
      end
      if (c == 7) begin
        chk("b2b rdata2", req_bus.resp_rdata, 32'h0000_0034);
        $display("txn B2B2 addr=0x012 rdata=0x%08h err=%0b", req_bus.resp_rdata, req_bus.resp_err);
      end
      if (c == 4) begin
        @(posedge clk);
        #1;
        req_bus.valid = 1'b0;
      end
    end

    // Reset in cycle 3 of a word store.
    @(negedge clk);
    req_bus.valid = 1'b1;
    req_bus.rw    = 1'b1;
    req_bus.size  = 2'b10;
    req_bus.sgn   = 1'b0;
    req_bus.addr  = 32'h020;
    req_bus.wdata = 32'h1122_3344;
    @(posedge clk);
    #1;
    req_bus.valid = 1'b0;
    @(negedge clk);
    chk("rstmid en c1", 32'(mem_bus.en), 32'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid en c4", 32'(mem_bus.en), 32'd0);
    chk("rstmid ready c4", 32'(req_bus.ready), 32'd1);
    chk("rstmid rvalid c4", 32'(req_bus.resp_valid), 32'd0);
    for (int c = 5; c <= 7; c++) begin
      @(negedge clk);
      chk($sformatf("rstmid rvalid c%0d", c), 32'(req_bus.resp_valid), 32'd0);
      chk($sformatf("rstmid en c%0d", c), 32'(mem_bus.en), 32'd0);
    end
    chk("rstmid byte20", 32'(mem_arr[9'h020]), 32'h11);
    chk("rstmid byte21", 32'(mem_arr[9'h021]), 32'h22);
    chk("rstmid byte23", 32'(mem_arr[9'h023]), 32'hEF);
    $display("txn RSTMID addr=0x020 mem20=0x%02h mem21=0x%02h", mem_arr[9'h020], mem_arr[9'h021]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
